regdst_pipe: RTL and testbench

//  Parametrised successor to the combinational RegDst mux.
//  - Selects the write-destination register from NSRC candidate fields (rt, rd, $ra, ...).
//  - Tracks that destination and its write-enable through DEPTH pipeline stages (EX..WB).
//  - Drives the WB destination and write-enable for the register file.
//  - Reports per-read-port RAW matches against in-flight destinations for forwarding/hazard logic.

---
 rtl/regdst_pkg.sv | 13 +
 rtl/regdst_if.sv | 37 +++
 rtl/regdst_match.sv | 30 +++
 rtl/regdst_pipe.sv | 92 +++++++++
 tb/tb_regdst_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/regdst_pkg.sv
// rtl/regdst_pkg.sv - shared constants for the destination-tracking pipe
package regdst_pkg;

  localparam int AW_DEF = 5;

  localparam logic [1:0] SEL_RT = 2'd0;
  localparam logic [1:0] SEL_RD = 2'd1;
  localparam logic [1:0] SEL_RA = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regdst_if.sv
// rtl/regdst_if.sv - issue/query/result bundle of the destination pipe
interface regdst_if
  import regdst_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int NSRC  = 3,
  parameter int SELW  = 2,
  parameter int DEPTH = 3,
  parameter int SW    = 2
);
  logic [SELW-1:0]     sel;
  logic [NSRC*AW-1:0]  src;
  logic                in_we;
  logic                stall;
  logic                flush;
  logic [AW-1:0]       qa;
  logic [AW-1:0]       qb;
  logic [DEPTH*AW-1:0] stg_dst;
  logic [DEPTH-1:0]    stg_vld;
  logic [AW-1:0]       wb_dst;
  logic                wb_we;
  logic                hit_a;
  logic                hit_b;
  logic [SW-1:0]       fwd_a;
  logic [SW-1:0]       fwd_b;
  logic                sel_err;

  modport master (
    output sel, src, in_we, stall, flush, qa, qb,
    input  stg_dst, stg_vld, wb_dst, wb_we, hit_a, hit_b, fwd_a, fwd_b, sel_err
  );

  modport slave (
    input  sel, src, in_we, stall, flush, qa, qb,
    output stg_dst, stg_vld, wb_dst, wb_we, hit_a, hit_b, fwd_a, fwd_b, sel_err
  );
endinterface

// File: rtl/regdst_match.sv
// rtl/regdst_match.sv - one read-port RAW lookup over the in-flight destinations
module regdst_match
  import regdst_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 3,
  parameter int SW    = 2
) (
  input  logic [DEPTH*AW-1:0] stg_dst,
  input  logic [DEPTH-1:0]    stg_vld,
  input  logic [AW-1:0]       q,
  output logic                hit,
  output logic [SW-1:0]       fwd
);

  // Scan oldest to youngest so the youngest producer is the last to win.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    if (q != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (stg_vld[k] && (stg_dst[k*AW +: AW] == q)) begin
          hit = 1'b1;
          fwd = SW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/regdst_pipe.sv
// rtl/regdst_pipe.sv - destination select, EX..WB tracking and RAW match
module regdst_pipe
  import regdst_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int NSRC  = 3,
  parameter int SELW  = 2,
  parameter int DEPTH = 3,
  parameter int SW    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  regdst_if.slave  io
);

  logic [AW-1:0]       cand;
  logic                sel_ok;
  logic                cap_vld;
  logic [AW-1:0]       dst_q [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic                err_q;
  logic [DEPTH*AW-1:0] dst_flat;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(io.sel) == i) cand = io.src[i*AW +: AW];
    end
  end

  assign sel_ok  = int'(io.sel) < NSRC;
  assign cap_vld = io.in_we & sel_ok & (cand != '0);

  // Stage 1 takes a bubble only on a pure stall; flush lets stage 0 advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) dst_q[k] <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (io.in_we && !sel_ok) err_q <= 1'b1;

      if (io.flush) begin
        vld_q[0] <= 1'b0;
        dst_q[0] <= '0;
      end else if (!io.stall) begin
        vld_q[0] <= cap_vld;
        dst_q[0] <= cand;
      end

      if (io.stall && !io.flush) begin
        vld_q[1] <= 1'b0;
        dst_q[1] <= '0;
      end else begin
        vld_q[1] <= vld_q[0];
        dst_q[1] <= dst_q[0];
      end

      for (int k = 2; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign dst_flat[k*AW +: AW] = dst_q[k];
  end

  assign io.stg_dst = dst_flat;
  assign io.stg_vld = vld_q;
  assign io.wb_dst  = dst_q[DEPTH-1];
  assign io.wb_we   = vld_q[DEPTH-1];
  assign io.sel_err = err_q;

  regdst_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match_a (
    .stg_dst (dst_flat),
    .stg_vld (vld_q),
    .q       (io.qa),
    .hit     (io.hit_a),
    .fwd     (io.fwd_a)
  );

  regdst_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match_b (
    .stg_dst (dst_flat),
    .stg_vld (vld_q),
    .q       (io.qb),
    .hit     (io.hit_b),
    .fwd     (io.fwd_b)
  );

endmodule

// File: tb/tb_regdst_pipe.sv
// tb/tb_regdst_pipe.sv - queue-model bench for regdst_pipe
module tb_regdst_pipe;
  import regdst_pkg::*;

  localparam int AW    = 5;
  localparam int NSRC  = 3;
  localparam int SELW  = 2;
  localparam int DEPTH = 3;
  localparam int SW    = 2;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   en = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  ent_t pipe[$];
  logic m_err;

  logic [DEPTH*AW-1:0] ed;
  logic [DEPTH-1:0]    ev;
  logic                eh_a, eh_b;
  logic [SW-1:0]       ef_a, ef_b;

  regdst_if #(.AW(AW), .NSRC(NSRC), .SELW(SELW), .DEPTH(DEPTH), .SW(SW)) bus ();

  regdst_pipe #(.AW(AW), .NSRC(NSRC), .SELW(SELW), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%0d exp=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back('0);
    m_err = 1'b0;
  endtask

  // Pipeline as a queue: the front is the youngest stage, the back is WB.
  task automatic model_step();
    ent_t          e;
    logic [AW-1:0] c;
    if (!rst_n) return;
    c   = (int'(bus.sel) < NSRC) ? AW'(bus.src >> (int'(bus.sel) * AW)) : '0;
    e.v = bus.in_we && (int'(bus.sel) < NSRC) && (c != '0);
    e.d = c;
    if (bus.in_we && int'(bus.sel) >= NSRC) m_err = 1'b1;
    if (bus.flush) begin
      pipe.push_front('0);
      void'(pipe.pop_back());
    end else if (bus.stall) begin
      pipe.insert(1, '0);
      void'(pipe.pop_back());
    end else begin
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
  endtask

  task automatic find(input logic [AW-1:0] q, output logic h, output logic [SW-1:0] f);
    h = 1'b0;
    f = '0;
    if (q != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!h && pipe[k].v && pipe[k].d == q) begin
          h = 1'b1;
          f = k[SW-1:0];
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < DEPTH; k++) begin
        ed[k*AW +: AW] = pipe[k].d;
        ev[k]          = pipe[k].v;
      end
      find(bus.qa, eh_a, ef_a);
      find(bus.qb, eh_b, ef_b);
      chk("stg_dst", 32'(bus.stg_dst), 32'(ed));
      chk("stg_vld", 32'(bus.stg_vld), 32'(ev));
      chk("wb_dst",  32'(bus.wb_dst),  32'(pipe[DEPTH-1].d));
      chk("wb_we",   32'(bus.wb_we),   32'(pipe[DEPTH-1].v));
      chk("hit_a",   32'(bus.hit_a),   32'(eh_a));
      chk("fwd_a",   32'(bus.fwd_a),   32'(ef_a));
      chk("hit_b",   32'(bus.hit_b),   32'(eh_b));
      chk("fwd_b",   32'(bus.fwd_b),   32'(ef_b));
      chk("sel_err", 32'(bus.sel_err), 32'(m_err));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sel = '0; bus.src = '0; bus.in_we = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.qa = '0; bus.qb = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_vld", 32'(bus.stg_vld), 0);
    chk("rst_wb_we", 32'(bus.wb_we), 0);
    chk("rst_sel_err", 32'(bus.sel_err), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    en = 1'b1;

    // Select rd of {31,9,8}: capture then walk to WB
    bus.sel = SEL_RD; bus.src = {5'd31, 5'd9, 5'd8}; bus.in_we = 1'b1;
    cyc();
    #1;
    chk("t2_stg0_dst", 32'(bus.stg_dst[4:0]), 9);
    chk("t2_stg0_vld", 32'(bus.stg_vld[0]), 1);
    bus.in_we = 1'b0;
    cyc();
    cyc();
    bus.qa = 5'd9;
    #1;
    chk("t2_wb_dst", 32'(bus.wb_dst), 9);
    chk("t2_wb_we", 32'(bus.wb_we), 1);
    chk("t2_fwd_wb", 32'(bus.fwd_a), 2);

    // $0 is never tracked
    bus.sel = SEL_RT; bus.src = {5'd31, 5'd9, 5'd0}; bus.in_we = 1'b1; bus.qa = 5'd0;
    cyc();
    #1;
    chk("t3_vld0", 32'(bus.stg_vld[0]), 0);
    chk("t3_hit_a", 32'(bus.hit_a), 0);
    bus.in_we = 1'b0;
    repeat (3) cyc();

    // Duplicate dst 7: youngest wins, survives a stall bubble
    bus.sel = SEL_RT; bus.src = {5'd31, 5'd9, 5'd7}; bus.in_we = 1'b1; bus.qa = 5'd7;
    cyc();
    cyc();
    #1;
    chk("t4_hit_a", 32'(bus.hit_a), 1);
    chk("t4_fwd_a", 32'(bus.fwd_a), 0);
    bus.stall = 1'b1;
    cyc();
    #1;
    chk("t4_stall_vld", 32'(bus.stg_vld), 32'b101);
    chk("t4_stall_fwd", 32'(bus.fwd_a), 0);
    bus.stall = 1'b0; bus.in_we = 1'b0;

    // Stall and flush together; then out-of-range select
    bus.src = {5'd31, 5'd9, 5'd4}; bus.in_we = 1'b1; bus.qb = 5'd4;
    cyc();
    bus.stall = 1'b1; bus.flush = 1'b1;
    cyc();
    #1;
    chk("t5_stg0_dst", 32'(bus.stg_dst[4:0]), 0);
    chk("t5_stg1_dst", 32'(bus.stg_dst[9:5]), 4);
    chk("t5_vld01", 32'(bus.stg_vld[1:0]), 32'b10);
    chk("t5_fwd_b", 32'(bus.fwd_b), 1);
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.sel = 2'd3;
    cyc();
    #1;
    chk("t5_sel_err", 32'(bus.sel_err), 1);
    chk("t5_bad_vld0", 32'(bus.stg_vld[0]), 0);
    bus.sel = SEL_RT; bus.in_we = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t5_sel_err_sticky", 32'(bus.sel_err), 1);

    // Mixed directed sweep over selects, stalls and flushes
    for (int i = 0; i < 24; i++) begin
      bus.sel   = SELW'(i % 4);
      bus.src   = {AW'((i * 5) % 8), AW'((i + 3) % 8), AW'(i % 8)};
      bus.in_we = (i % 3) != 0;
      bus.stall = (i % 5) == 2;
      bus.flush = (i % 7) == 3;
      bus.qa    = AW'((i * 3) % 8);
      bus.qb    = AW'((i + 1) % 6);
      cyc();
    end
    bus.stall = 1'b0; bus.flush = 1'b0;

    // Fill all stages ($ra, rd, rt) and reset mid-stream
    bus.src = {5'd31, 5'd9, 5'd8}; bus.in_we = 1'b1;
    bus.sel = SEL_RA; cyc();
    bus.sel = SEL_RD; cyc();
    bus.sel = SEL_RT; cyc();
    bus.qa = 5'd9; bus.qb = REG_RA;
    #1;
    chk("t1_full_vld", 32'(bus.stg_vld), 32'b111);
    chk("t1_fwd_a", 32'(bus.fwd_a), 1);
    chk("t1_fwd_b", 32'(bus.fwd_b), 2);
    chk("t1_wb_dst", 32'(bus.wb_dst), 31);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_rst_wb_we", 32'(bus.wb_we), 0);
    chk("t1_rst_vld", 32'(bus.stg_vld), 0);
    chk("t1_rst_sel_err", 32'(bus.sel_err), 0);
    chk("t1_rst_hit_b", 32'(bus.hit_b), 0);
    cyc();
    rst_n = 1'b1;
    bus.in_we = 1'b0;
    cyc();
    cyc();
    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
